// File: rtl/dcache_rr_buffer.sv
// Round-robin write collector for four IPs feeding the Dcache buffered write port.
// Optional feature: define DCACHE_RR_SEGCHK_EN to drop and flag writes outside each IP's segment.
module dcache_rr_buffer #(
    parameter int N        = 32,
    parameter int DEPTH    = 4,
    parameter int SEG_BASE = 48,
    parameter int SEG_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [3:0]               wr_req,
    input  logic [N-1:0]             wr_addr1,
    input  logic [N-1:0]             wr_addr2,
    input  logic [N-1:0]             wr_addr3,
    input  logic [N-1:0]             wr_addr4,
    input  logic [N-1:0]             wr_data1,
    input  logic [N-1:0]             wr_data2,
    input  logic [N-1:0]             wr_data3,
    input  logic [N-1:0]             wr_data4,
    output logic [3:0]               wr_ack,
    input  logic                     sc_busy,
    output logic                     DWRR,
    output logic [N-1:0]             DARR,
    output logic [N-1:0]             DORR,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic [3:0]               err
);

    localparam int PW = $clog2(DEPTH);

`ifdef DCACHE_RR_SEGCHK_EN
    localparam bit SEGCHK = 1'b1;
`else
    localparam bit SEGCHK = 1'b0;
`endif

    typedef struct packed {
        logic [N-1:0] addr;
        logic [N-1:0] data;
    } entry_t;

    entry_t         r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [PW:0]    r_count;
    logic [1:0]     r_rr_ptr;
    logic           r_dwrr;
    logic [N-1:0]   r_darr;
    logic [N-1:0]   r_dorr;
    logic [3:0]     r_err;

    logic           w_any;
    logic [1:0]     w_win;
    logic           w_full;
    logic           w_grant;
    logic           w_in_seg;
    logic           w_push;
    logic           w_pop;
    logic [N-1:0]   w_addr;
    logic [N-1:0]   w_data;
    logic [N:0]     w_seg_lo;
    logic [PW:0]    w_count_nxt;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = 1; i <= 4; i++) begin
            if (!w_any && wr_req[r_rr_ptr + 2'(i)]) begin
                w_any = 1'b1;
                w_win = r_rr_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_addr = wr_addr1;
        w_data = wr_data1;
        case (w_win)
            2'd1:    begin w_addr = wr_addr2; w_data = wr_data2; end
            2'd2:    begin w_addr = wr_addr3; w_data = wr_data3; end
            2'd3:    begin w_addr = wr_addr4; w_data = wr_data4; end
            default: begin w_addr = wr_addr1; w_data = wr_data1; end
        endcase
    end

    // Fullness uses the registered count: a pop on the same edge never frees a slot for a push.
    assign w_full   = (r_count == (PW+1)'(DEPTH));
    assign w_grant  = w_any && !w_full;
    assign wr_ack   = w_grant ? (4'b0001 << w_win) : 4'b0000;

    assign w_seg_lo = (N+1)'(SEG_BASE) + (N+1)'(SEG_SIZE) * (N+1)'(w_win);
    assign w_in_seg = ({1'b0, w_addr} >= w_seg_lo) &&
                      ({1'b0, w_addr} <  w_seg_lo + (N+1)'(SEG_SIZE));

    assign w_push   = w_grant && (!SEGCHK || w_in_seg);
    assign w_pop    = (r_count != '0) && !sc_busy;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (PW+1)'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - (PW+1)'(1);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= 2'd3;
            r_dwrr   <= 1'b0;
            r_darr   <= '0;
            r_dorr   <= '0;
            r_err    <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_grant)
                r_rr_ptr <= w_win;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_grant && !w_push)
                r_err[w_win] <= 1'b1;
            r_dwrr <= w_pop;
            if (w_pop) begin
                r_darr   <= r_mem[r_rd_ptr].addr;
                r_dorr   <= r_mem[r_rd_ptr].data;
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; resetting the pointers and count already discards its contents.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= '{addr: w_addr, data: w_data};
    end

    assign DWRR       = r_dwrr;
    assign DARR       = r_darr;
    assign DORR       = r_dorr;
    assign fifo_count = r_count;
    assign fifo_full  = w_full;
    assign err        = r_err;

endmodule

// File: tb/tb_dcache_rr_buffer.sv
// Self-checking bench for dcache_rr_buffer: directed scenarios plus random traffic against a queue-based model.
// Honours DCACHE_RR_SEGCHK_EN the same way the design does.
module tb_dcache_rr_buffer;

    localparam int N        = 32;
    localparam int DEPTH    = 4;
    localparam int SEG_BASE = 48;
    localparam int SEG_SIZE = 16;

`ifdef DCACHE_RR_SEGCHK_EN
    localparam bit SEGCHK = 1'b1;
`else
    localparam bit SEGCHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   wr_req = '0;
    logic [N-1:0] wr_addr1 = '0, wr_addr2 = '0, wr_addr3 = '0, wr_addr4 = '0;
    logic [N-1:0] wr_data1 = '0, wr_data2 = '0, wr_data3 = '0, wr_data4 = '0;
    logic [3:0]   wr_ack;
    logic         sc_busy = 1'b0;
    logic         DWRR;
    logic [N-1:0] DARR, DORR;
    logic [2:0]   fifo_count;
    logic         fifo_full;
    logic [3:0]   err;

    always #5 clk = ~clk;

    dcache_rr_buffer #(.N(N), .DEPTH(DEPTH), .SEG_BASE(SEG_BASE), .SEG_SIZE(SEG_SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req),
        .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3), .wr_addr4(wr_addr4),
        .wr_data1(wr_data1), .wr_data2(wr_data2), .wr_data3(wr_data3), .wr_data4(wr_data4),
        .wr_ack(wr_ack), .sc_busy(sc_busy), .DWRR(DWRR), .DARR(DARR), .DORR(DORR),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .err(err)
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] d;
    } word_t;

    word_t        mq[$];
    int           m_rr;
    logic [3:0]   m_err;
    logic         m_dwrr;
    logic [N-1:0] m_darr, m_dorr;

    bit           pend [4];
    logic [N-1:0] paddr [4];
    logic [N-1:0] pdata [4];
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_seg(input int k, input logic [N-1:0] a);
        longint lo;
        lo = longint'(SEG_BASE) + longint'(SEG_SIZE) * k;
        return (longint'(a) >= lo) && (longint'(a) < lo + SEG_SIZE);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rr   = 3;
        m_err  = '0;
        m_dwrr = 1'b0;
        m_darr = '0;
        m_dorr = '0;
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;
    endtask

    task automatic new_word(input int k, input int bad_pct);
        if (int'($urandom_range(99)) < bad_pct)
            paddr[k] = N'($urandom_range(255));
        else
            paddr[k] = N'(SEG_BASE + SEG_SIZE * k) + N'($urandom_range(SEG_SIZE - 1));
        pdata[k] = $urandom;
        pend[k]  = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".DWRR"}, 64'(DWRR), 64'(m_dwrr));
        check({tag, ".count"}, 64'(fifo_count), 64'(mq.size()));
        check({tag, ".full"}, 64'(fifo_full), 64'(mq.size() == DEPTH));
        check({tag, ".err"}, 64'(err), 64'(m_err));
        if (m_dwrr) begin
            check({tag, ".DARR"}, 64'(DARR), 64'(m_darr));
            check({tag, ".DORR"}, 64'(DORR), 64'(m_dorr));
        end
    endtask

    // One clock cycle: entered and left 1 time unit after a rising edge.
    task automatic step(input string tag);
        int    win;
        int    k;
        word_t w;
        wr_req   = {pend[3], pend[2], pend[1], pend[0]};
        wr_addr1 = paddr[0]; wr_addr2 = paddr[1]; wr_addr3 = paddr[2]; wr_addr4 = paddr[3];
        wr_data1 = pdata[0]; wr_data2 = pdata[1]; wr_data3 = pdata[2]; wr_data4 = pdata[3];
        sc_busy  = busy;
        #2;
        win = -1;
        if (mq.size() < DEPTH)
            for (int i = 1; i <= 4; i++) begin
                k = (m_rr + i) % 4;
                if (win < 0 && pend[k]) win = k;
            end
        check({tag, ".ack"}, 64'(wr_ack), (win >= 0) ? 64'(1) << win : 64'(0));
        if (mq.size() > 0 && !busy) begin
            w      = mq.pop_front();
            m_dwrr = 1'b1;
            m_darr = w.a;
            m_dorr = w.d;
        end else begin
            m_dwrr = 1'b0;
        end
        if (win >= 0) begin
            m_rr = win;
            if (SEGCHK && !in_seg(win, paddr[win]))
                m_err[win] = 1'b1;
            else
                mq.push_back('{a: paddr[win], d: pdata[win]});
        end
        @(posedge clk);
        #1;
        check_regs(tag);
        if (win >= 0) pend[win] = 1'b0;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        model_reset();
        busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_regs("reset");
    endtask

    task automatic drain(input string tag);
        busy = 1'b0;
        for (int c = 0; c < 3 * DEPTH && (mq.size() > 0 || m_dwrr); c++) step(tag);
        check({tag, ".drained"}, 64'(fifo_count), 64'(0));
    endtask

    initial begin
        model_reset();
        busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            paddr[k] = '0;
            pdata[k] = '0;
        end
        #12;
        hard_reset();

        // Single write from IP2 into an empty FIFO.
        paddr[1] = 32'd64; pdata[1] = 32'hA5A5_0001; pend[1] = 1'b1;
        step("single0");
        step("single1");
        check("single.DARR", 64'(DARR), 64'd64);
        step("single2");

        // All four IPs request continuously after reset: IP1 first.
        hard_reset();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 4; k++) if (!pend[k]) new_word(k, 0);
            step("rr");
        end
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;
        drain("rr_drain");

        // Back-pressure while the security controller owns the array, then release.
        busy = 1'b1;
        for (int c = 0, sent = 0; c < 8; c++) begin
            if (!pend[0] && sent < 6) begin new_word(0, 0); sent++; end
            step("bp_busy");
        end
        check("bp.full", 64'(fifo_full), 64'(1));
        busy = 1'b0;
        for (int c = 0; c < 10; c++) step("bp_drain");

        // Out-of-segment write from IP3.
        hard_reset();
        paddr[2] = 32'd20; pdata[2] = 32'h0000_1234; pend[2] = 1'b1;
        step("seg0");
        step("seg1");
        step("seg2");
        check("seg.err", 64'(err), SEGCHK ? 64'b0100 : 64'b0000);

        // Asynchronous reset mid-drain with three entries held.
        hard_reset();
        busy = 1'b1;
        for (int k = 0; k < 3; k++) new_word(k, 0);
        for (int c = 0; c < 3; c++) step("mid_fill");
        busy = 1'b0;
        new_word(3, 0);
        step("mid_pushpop");
        check("mid.count3", 64'(fifo_count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.rst_DWRR", 64'(DWRR), 64'd0);
        check("mid.rst_count", 64'(fifo_count), 64'd0);
        check("mid.rst_err", 64'(err), 64'd0);
        model_reset();
        wr_req = '0;
        @(posedge clk);
        #1;
        check("mid.held_DWRR", 64'(DWRR), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) step("mid_after");

        // Random traffic with random security-controller activity.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++)
                if (!pend[k] && $urandom_range(1) == 1) new_word(k, 10);
            busy = ($urandom_range(3) == 0);
            step("rand");
        end
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
